// File: rtl/alu_arbiter3.sv
// Round-robin arbiter sharing one combinational ALU among three requesters.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (0 highest) instead of round-robin.
module alu_arbiter3 #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [8:0]       req_op,
  input  logic [3*W-1:0]   req_a,
  input  logic [3*W-1:0]   req_b,
  output logic [2:0]       alu_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_y,
  input  logic             alu_cout,
  output logic [2:0]       grant,
  output logic [2:0]       ack,
  output logic [W-1:0]     rsp_y,
  output logic             rsp_cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [1:0]     win;
  logic [2:0]     sel_op;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [1:0]     last;
`endif

  // Winner among pending requests; only meaningful when req != 0.
  always_comb begin
    win = 2'd0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
`else
    case (last)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  always_comb begin
    sel_op = req_op[2:0];
    sel_a  = req_a[W-1:0];
    sel_b  = req_b[W-1:0];
    case (win)
      2'd0: begin
        sel_op = req_op[2:0];
        sel_a  = req_a[W-1:0];
        sel_b  = req_b[W-1:0];
      end
      2'd1: begin
        sel_op = req_op[5:3];
        sel_a  = req_a[2*W-1:W];
        sel_b  = req_b[2*W-1:W];
      end
      default: begin
        sel_op = req_op[8:6];
        sel_a  = req_a[3*W-1:2*W];
        sel_b  = req_b[3*W-1:2*W];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      alu_op   <= 3'd0;
      alu_a    <= '0;
      alu_b    <= '0;
      grant    <= 3'd0;
      ack      <= 3'd0;
      rsp_y    <= '0;
      rsp_cout <= 1'b0;
      busy     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last     <= 2'd2;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= 3'd0;
          if (|req) begin
            alu_op <= sel_op;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            grant  <= 3'b001 << win;
            cnt    <= 4'(LAT - 1);
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        // Operands held stable while the ALU settles; result sampled on the last EXEC cycle.
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_y    <= alu_y;
            rsp_cout <= alu_cout;
            ack      <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last     <= grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);
`endif
            state    <= RESP;
          end
        end
        RESP: begin
          ack   <= 3'd0;
          grant <= 3'd0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter3.md
# alu_arbiter3

Shares one combinational ALU (built from the OR3/NOR3 gate library) among three requesters. A round-robin arbiter picks one pending request, latches its opcode and operands, and drives them onto the shared ALU for `LAT` cycles. It then captures the result and returns it with a one-cycle acknowledge to the winning requester. It sits between the three client blocks and the ALU datapath and is the only driver of the ALU inputs.

## Interface
Parameters:
- `W`, 8: operand and result width.
- `LAT`, 1: ALU settle cycles, 1..15; the number of EXEC cycles the operands are held before `alu_y` is sampled.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 3: request bit per requester; held high until that requester's `ack`.
- `req_op` in 9: opcode `{op2,op1,op0}`, 3 bits each.
- `req_a` in 3*W: operand A `{a2,a1,a0}`.
- `req_b` in 3*W: operand B `{b2,b1,b0}`.
- `alu_op` out 3: opcode to the ALU (registered).
- `alu_a` out W: operand A to the ALU (registered).
- `alu_b` out W: operand B to the ALU (registered).
- `alu_y` in W: ALU result.
- `alu_cout` in 1: ALU carry/flag.
- `grant` out 3: one-hot current owner; zero in IDLE.
- `ack` out 3: one-hot, one-cycle result-valid pulse.
- `rsp_y` out W: captured result; valid when `ack != 0`, held afterwards.
- `rsp_cout` out 1: captured carry, same validity as `rsp_y`.
- `busy` out 1: high in EXEC and RESP.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset enters IDLE.
- **IDLE**
  - If `req == 0`, the block stays in IDLE.
  - Otherwise it selects a winner `g` by round-robin, searching from `last+1` mod 3 upward.
  - It latches `req_op`, `req_a` and `req_b` slice `g` into `alu_op`, `alu_a` and `alu_b`.
  - It sets `grant = 1<<g`, loads `cnt = LAT-1` and moves to EXEC.
- **EXEC**
  - The ALU inputs stay stable.
  - If `cnt != 0`, `cnt` decrements.
  - If `cnt == 0`, the block captures `alu_y` and `alu_cout` into `rsp_y` and `rsp_cout`, sets `last = g` and moves to RESP.
- **RESP**
  - `ack[g] = 1` for exactly this cycle; `grant` is still held.
  - The block then moves to IDLE and clears `grant`.
- The winner's request is sampled only at grant time:
  - Deasserting `req[g]` or changing its operands during EXEC/RESP has no effect.
  - The `ack` is still issued.
- Requests from the other requesters stay pending and are never dropped or reordered.
- A requester whose `req` is still high in the IDLE cycle after its `ack` is treated as a new request.
- Width rules:
  - The arbiter never modifies data.
  - `rsp_y` is `alu_y` truncated or exact at `W` bits.
  - `alu_cout` passes through unchanged.

## Timing
- Reset values: `alu_op = 0`, `alu_a = 0`, `alu_b = 0`, `grant = 0`, `ack = 0`, `rsp_y = 0`, `rsp_cout = 0`, `busy = 0`, `last = 2` (so requester 0 wins first), `cnt = 0`, state = IDLE.
- Latency: with `req` high in IDLE cycle t, EXEC spans t+1..t+LAT and `ack` is high in cycle t+LAT+1.
- Throughput: one operation per LAT+2 cycles.
- With all three requesters permanently requesting, grants rotate 0,1,2,0,… and no requester waits more than 2 operations.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately (asynchronous).
  - The in-flight operation is lost and no `ack` is issued.
  - After release the block is in IDLE.
- `req` bits for the current owner are ignored while `busy`.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
- When defined: fixed priority, requester 0 highest and 2 lowest; `last` is not used.
- When undefined (default): round-robin as described above.
- Interface and timing are identical in both builds.

## Test plan
Bench conditions: W=8, LAT=1. Bench ALU model: op 0 = a|b, op 1 = ~(a|b), op 2 = a+b with carry.

- **Reset:** hold `rst` for 2 cycles -> all outputs 0, `busy = 0`. Assert `rst` in the middle of EXEC -> outputs 0 the same cycle, no `ack` afterwards.
- **Single request:** `req = 001`, op 0, a = 8'h0F, b = 8'hF0 -> `ack = 001` exactly 2 cycles later, `rsp_y = 8'hFF`. Repeat with op 1 -> `rsp_y = 8'h00`.
- **Add with carry:** `req = 100`, op 2, a = 8'hFF, b = 8'h02 -> `ack = 100`, `rsp_y = 8'h01`, `rsp_cout = 1`.
- **Fairness:** hold `req = 111` with distinct operands -> `ack` sequence 001, 010, 100, 001, one every 3 cycles, each `rsp_y` matching its own operands.
- **Request drop after grant:** drop `req[1]` the cycle after its grant -> `ack = 010` is still issued, with the result computed from the operands latched at grant.
- **LAT=3 build:** `req = 010` -> `busy` high for 4 cycles, `ack` 4 cycles after the request. With `ALU_ARB_FIXED_PRIO_EN` defined and `req = 111` held -> requester 0 is acked repeatedly.
